// File: rtl/regfile_dump_sched_if.sv
// Signal bundle between the register-file dump scheduler and its neighbours:
// the dump controls, the shared read port, the UART TX byte path and the status outputs.
interface regfile_dump_sched_if #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int ADDR_BUS_WIDTH = 5
);
  logic                      start;
  logic                      abort;
  logic                      pipe_rd_req;
  logic [ADDR_BUS_WIDTH-1:0] pipe_addr;
  logic [ADDR_BUS_WIDTH-1:0] rf_addr;
  logic [DATA_BUS_WIDTH-1:0] rf_data;
  logic                      tx_busy;
  logic [7:0]                tx_data;
  logic                      tx_valid;
  logic                      busy;
  logic                      done;

  // Surroundings: pipeline, register file, UART and the dump requester.
  modport master (
    output start, abort, pipe_rd_req, pipe_addr, rf_data, tx_busy,
    input  rf_addr, tx_data, tx_valid, busy, done
  );

  // The scheduler itself.
  modport slave (
    input  start, abort, pipe_rd_req, pipe_addr, rf_data, tx_busy,
    output rf_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/regfile_dump_sched.sv
// Streams every register to the UART one byte at a time, reading the register file only
// on cycles the pipeline leaves the shared read port free. Abortable at any point.
module regfile_dump_sched #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int ADDR_BUS_WIDTH = 5,
  parameter int NUM_REGS       = 32,
  parameter bit MSB_FIRST      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_dump_sched_if.slave  bus
);

  localparam int NUM_BYTES = DATA_BUS_WIDTH / 8;
  localparam int BIW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BIW-1:0]            LAST_BYTE = BIW'(NUM_BYTES - 1);
  localparam logic [ADDR_BUS_WIDTH-1:0] LAST_REG  = ADDR_BUS_WIDTH'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT_TX = 3'd2,
    SEND    = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                    state_reg,    state_next;
  logic [ADDR_BUS_WIDTH-1:0] reg_idx_reg,  reg_idx_next;
  logic [BIW-1:0]            byte_idx_reg, byte_idx_next;
  logic [DATA_BUS_WIDTH-1:0] shift_reg,    shift_next;
  logic [7:0]                tx_data_reg,  tx_data_next;

  logic [7:0]                head_byte;
  logic [DATA_BUS_WIDTH-1:0] shifted_word;

  // The byte due next always sits at one end of the shift register; after it is sent the
  // word moves by one byte so the following byte takes its place.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign head_byte    = shift_reg[DATA_BUS_WIDTH-1 -: 8];
      assign shifted_word = shift_reg << 8;
    end else begin : g_lsb_first
      assign head_byte    = shift_reg[7:0];
      assign shifted_word = shift_reg >> 8;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      reg_idx_reg  <= '0;
      byte_idx_reg <= '0;
      shift_reg    <= '0;
      tx_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      reg_idx_reg  <= reg_idx_next;
      byte_idx_reg <= byte_idx_next;
      shift_reg    <= shift_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    reg_idx_next  = reg_idx_reg;
    byte_idx_next = byte_idx_reg;
    shift_next    = shift_reg;
    tx_data_next  = tx_data_reg;

    if (bus.abort) begin
      // Abort wins over start in IDLE and drops any dump in progress without a done pulse.
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_next    = FETCH;
            reg_idx_next  = '0;
            byte_idx_next = '0;
          end
        end
        FETCH: begin
          if (!bus.pipe_rd_req) begin
            shift_next    = bus.rf_data;
            byte_idx_next = '0;
            state_next    = WAIT_TX;
          end
        end
        WAIT_TX: begin
          // Loading the byte here lets it sit on tx_data for the whole SEND cycle.
          if (!bus.tx_busy) begin
            tx_data_next = head_byte;
            state_next   = SEND;
          end
        end
        SEND: begin
          state_next = GAP;
        end
        GAP: begin
          if (byte_idx_reg < LAST_BYTE) begin
            byte_idx_next = byte_idx_reg + 1'b1;
            shift_next    = shifted_word;
            state_next    = WAIT_TX;
          end else if (reg_idx_reg < LAST_REG) begin
            reg_idx_next = reg_idx_reg + 1'b1;
            state_next   = FETCH;
          end else begin
            state_next = DONE;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // The pipeline owns the read port whenever it asks for it; the dump never stalls it.
  assign bus.rf_addr  = bus.pipe_rd_req ? bus.pipe_addr : reg_idx_reg;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_valid = (state_reg == SEND);
  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == DONE);

endmodule

// File: tb/tb_regfile_dump_sched.sv
// Bench for regfile_dump_sched: two instances (MSB-first and LSB-first) share one stimulus;
// a reference model queues the expected bytes and a monitor compares every tx_valid.
module tb_regfile_dump_sched;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int NB = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, abort, pipe_rd_req, tx_busy;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] mem [NR];

  regfile_dump_sched_if #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW)) if0 ();
  regfile_dump_sched_if #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW)) if1 ();

  assign if0.start = start;        assign if1.start = start;
  assign if0.abort = abort;        assign if1.abort = abort;
  assign if0.pipe_rd_req = pipe_rd_req;  assign if1.pipe_rd_req = pipe_rd_req;
  assign if0.pipe_addr = pipe_addr;      assign if1.pipe_addr = pipe_addr;
  assign if0.tx_busy = tx_busy;    assign if1.tx_busy = tx_busy;
  assign if0.rf_data = mem[if0.rf_addr];
  assign if1.rf_data = mem[if1.rf_addr];

  regfile_dump_sched #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .NUM_REGS(NR), .MSB_FIRST(1'b1))
    dut_msb (.clk(clk), .rst(rst_n), .bus(if0.slave));
  regfile_dump_sched #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .NUM_REGS(NR), .MSB_FIRST(1'b0))
    dut_lsb (.clk(clk), .rst(rst_n), .bus(if1.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard queues and monitor.
  logic [7:0] q0[$], q1[$];
  int ts0[$];
  int sent0 = 0, sent1 = 0, done0 = 0, done1 = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (if0.tx_valid === 1'b1) begin
        sent0++;
        ts0.push_back(cyc);
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte_msb: got %02h required no byte", if0.tx_data);
        end else check("byte_msb", if0.tx_data, q0.pop_front());
      end
      if (if1.tx_valid === 1'b1) begin
        sent1++;
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte_lsb: got %02h required no byte", if1.tx_data);
        end else check("byte_lsb", if1.tx_data, q1.pop_front());
      end
      if (if0.done === 1'b1) done0++;
      if (if1.done === 1'b1) done1++;
    end
  end

  // UART model: busy for n cycles starting the cycle after a byte is accepted.
  int uart_len = 10;
  bit uart_rand = 1'b0;
  initial begin
    int n;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (if0.tx_valid === 1'b1) begin
        n = uart_rand ? int'($urandom_range(1, 12)) : uart_len;
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (n) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Reference model: the first n bytes of a dump from register 0, in both byte orders.
  task automatic push_bytes(int n);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = mem[k / NB];
      q0.push_back(w[8*(NB-1-(k % NB)) +: 8]);
      q1.push_back(w[8*(k % NB) +: 8]);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NR; i++) mem[i] = $urandom;
    mem[0] = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(output int c);
    tick();
    start = 1'b1;
    c = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_sent(int target, int budget, string name);
    for (int i = 0; i < budget && sent0 < target; i++) begin
      @(negedge clk); #1;
    end
    check(name, (sent0 >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_done(int budget, bit rand_pipe, string name);
    int d;
    d = done0;
    for (int i = 0; i < budget && done0 == d; i++) begin
      if (rand_pipe) begin
        @(posedge clk); #1;
        pipe_rd_req = ($urandom_range(0, 2) == 0);
        pipe_addr   = AW'($urandom);
      end
      @(negedge clk); #1;
    end
    pipe_rd_req = 1'b0;
    check(name, done0, d + 1);
  endtask

  initial begin
    int c, base, d;
    start = 0; abort = 0; pipe_rd_req = 0; pipe_addr = '0; rst_n = 1'b0;
    for (int i = 0; i < NR; i++) mem[i] = DW'(i);

    // Reset state
    @(negedge clk);
    check("rst_busy", if0.busy, 0);
    check("rst_tx_valid", if0.tx_valid, 0);
    check("rst_done", if0.done, 0);
    check("rst_tx_data", if0.tx_data, 0);
    check("rst_rf_addr", if0.rf_addr, 0);
    tick(); rst_n = 1'b1;
    repeat (3) tick();

    // Full uncontended dump, R[i]=i, start pulses ignored during reg 10
    push_bytes(NR * NB);
    base = sent0; d = done0;
    pulse_start(c);
    wait_sent(base + 1, 20, "first_byte_timeout");
    if (ts0.size() > base) check("start_latency", ts0[base] - c, 3);
    wait_sent(base + 10 * NB + 1, 3000, "reg10_timeout");
    tick(); start = 1'b1; tick(); tick(); start = 1'b0;
    wait_done(3000, 1'b0, "done_full");
    check("busy_in_done", if0.busy, 1);
    @(negedge clk);
    check("busy_after_done", if0.busy, 0);
    repeat (20) @(negedge clk);
    check("bytes_full", sent0 - base, NR * NB);
    check("single_done", done0, d + 1);
    check("lsb_done_match", done1, done0);

    // Start and abort together in IDLE
    tick(); start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", if0.busy, 0);

    // Port contention during FETCH of reg 3; R[1]=0x12345678 checks both byte orders
    fill_random();
    mem[1] = 32'h12345678;
    uart_len = 1;
    push_bytes(NR * NB);
    base = sent0;
    pulse_start(c);
    wait_sent(base + 3 * NB, 500, "reg2_timeout");
    @(posedge clk);
    tick();
    pipe_rd_req = 1'b1; pipe_addr = AW'(7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rf_addr_pipe", if0.rf_addr, 7);
      tick();
    end
    pipe_rd_req = 1'b0;
    @(negedge clk);
    check("rf_addr_fetch", if0.rf_addr, 3);
    wait_sent(base + 3 * NB + 1, 50, "reg3_timeout");
    if (ts0.size() > base + 3 * NB)
      check("capture_delay", ts0[base + 3*NB] - ts0[base + 3*NB - 1], 4 + 5);
    wait_done(3000, 1'b0, "done_contention");
    uart_len = 10;
    repeat (20) tick();

    // Abort during WAIT_TX of reg 5 byte 2, then restart from reg 0
    fill_random();
    push_bytes(5 * NB + 2);
    base = sent0; d = done0;
    pulse_start(c);
    wait_sent(base + 5 * NB + 2, 2000, "abort_point_timeout");
    @(posedge clk);
    tick();
    abort = 1'b1;
    @(negedge clk);
    check("busy_before_abort", if0.busy, 1);
    tick(); abort = 1'b0;
    @(negedge clk);
    check("busy_after_abort", if0.busy, 0);
    repeat (40) @(negedge clk);
    check("bytes_abort", sent0 - base, 5 * NB + 2);
    check("no_done_abort", done0, d);
    push_bytes(NR * NB);
    base = sent0;
    pulse_start(c);
    wait_done(4000, 1'b0, "done_restart");
    check("bytes_restart", sent0 - base, NR * NB);
    repeat (20) tick();

    // Asynchronous reset between edges during SEND
    push_bytes(5);
    base = sent0; d = done0;
    pulse_start(c);
    wait_sent(base + 5, 500, "send_timeout");
    #1 rst_n = 1'b0;
    #1;
    check("arst_tx_valid", if0.tx_valid, 0);
    check("arst_busy", if0.busy, 0);
    check("arst_tx_data", if0.tx_data, 0);
    check("arst_tx_data_lsb", if1.tx_data, 0);
    tick(); rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("bytes_after_arst", sent0 - base, 5);
    check("idle_after_arst", if0.busy, 0);
    check("no_done_arst", done0, d);

    // Randomized dumps with random UART latency and random port contention
    uart_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      fill_random();
      push_bytes(NR * NB);
      base = sent0;
      pulse_start(c);
      wait_done(8000, 1'b1, "done_random");
      check("bytes_random", sent0 - base, NR * NB);
      repeat (20) tick();
    end

    check("queue_msb_empty", q0.size(), 0);
    check("queue_lsb_empty", q1.size(), 0);
    check("lsb_sent_match", sent1, sent0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
